// File: rtl/box_initiator.sv
// box_initiator: turns single read/write commands into box register-file strobes
// and returns one response per command, flagging reads that never see read_active.
module box_initiator #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // box register-file port
  output logic              box_read_enable,
  output logic              box_write_enable,
  output logic [DATA_W-1:0] box_write_data,
  output logic [ADDR_W-1:0] box_address,
  input  logic [DATA_W-1:0] box_read_data,
  input  logic              box_read_active,
  // status
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT,
    S_RESP
  } state_t;

  // The wait counter is sized for the largest legal TIMEOUT (255).
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              box_re_q, box_re_d;
  logic              box_we_q, box_we_d;
  logic [ADDR_W-1:0] box_addr_q, box_addr_d;
  logic [DATA_W-1:0] box_wdata_q, box_wdata_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              busy_q, busy_d;

  // Next-state and registered-output computation; every output is a flop.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    box_re_d    = 1'b0;
    box_we_d    = 1'b0;
    box_addr_d  = box_addr_q;
    box_wdata_d = box_wdata_q;
    wait_cnt_d  = wait_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          box_addr_d  = cmd_addr;
          box_wdata_d = cmd_wdata;
          if (cmd_write) begin
            box_we_d = 1'b1;
            state_d  = S_WRITE;
          end else begin
            box_re_d   = 1'b1;
            wait_cnt_d = '0;
            state_d    = S_READ;
          end
        end else begin
          // Also raises cmd_ready on the first edge after reset release.
          cmd_ready_d = 1'b1;
        end
      end

      S_WRITE: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        state_d     = S_RESP;
      end

      S_READ: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Data is tested before the timeout so it wins on the final wait edge.
        if (box_read_active) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = box_read_data;
          rsp_err_d   = 1'b0;
          state_d     = S_RESP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; asynchronous active-low reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      box_re_q    <= 1'b0;
      box_we_q    <= 1'b0;
      box_addr_q  <= '0;
      box_wdata_q <= '0;
      wait_cnt_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      box_re_q    <= box_re_d;
      box_we_q    <= box_we_d;
      box_addr_q  <= box_addr_d;
      box_wdata_q <= box_wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_err          = rsp_err_q;
  assign box_read_enable  = box_re_q;
  assign box_write_enable = box_we_q;
  assign box_write_data   = box_wdata_q;
  assign box_address      = box_addr_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_box_initiator.sv
// Testbench for box_initiator: directed scenarios plus randomized commands,
// checked against a register-array reference model through a response scoreboard.
module tb_box_initiator;

  localparam int unsigned TO = 8;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       box_read_enable;
  logic       box_write_enable;
  logic [7:0] box_write_data;
  logic [1:0] box_address;
  logic [7:0] box_read_data;
  logic       box_read_active;
  logic       busy;

  box_initiator #(.DATA_W(8), .ADDR_W(2), .TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_write        (cmd_write),
    .cmd_addr         (cmd_addr),
    .cmd_wdata        (cmd_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .box_read_enable  (box_read_enable),
    .box_write_enable (box_write_enable),
    .box_write_data   (box_write_data),
    .box_address      (box_address),
    .box_read_data    (box_read_data),
    .box_read_active  (box_read_active),
    .busy             (busy)
  );

  typedef struct {
    logic [7:0]  rdata;
    logic        err;
    int unsigned cyc;
  } rsp_t;

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;
  } strobe_t;

  rsp_t        sb[$];
  strobe_t     st[$];
  logic [7:0]  ref_mem [4];
  logic [7:0]  box_mem [4];
  int unsigned cyc;
  int          box_lat;
  int          hold_left;
  int          n_vec;
  int          n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm, input string what);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s at cycle %0d", nm, what, cyc);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Box storage model: writes land at the strobe, reads answer box_lat edges after the strobe edge.
  initial begin
    for (int i = 0; i < 4; i++) box_mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (rst && box_write_enable) box_mem[box_address] = box_write_data;
    end
  end

  initial begin
    int         lat;
    logic [1:0] a;
    box_read_active = 1'b0;
    box_read_data   = 8'h00;
    forever begin
      @(negedge clk);
      if (rst && box_read_enable) begin
        lat = box_lat;
        a   = box_address;
        if (lat > 0) begin
          repeat (lat) @(posedge clk);
          #1;
          box_read_active = 1'b1;
          box_read_data   = box_mem[a];
          @(posedge clk);
          #1;
          box_read_active = 1'b0;
          box_read_data   = 8'($urandom);
        end
      end
    end
  end

  // Response consumer: withholds rsp_ready for hold_left cycles per response.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rsp_valid && hold_left > 0) begin
        hold_left--;
        rsp_ready = 1'b0;
      end else begin
        rsp_ready = rsp_valid;
      end
    end
  end

  // Monitor: pops the scoreboard on each new response and checks the box strobes.
  initial begin
    rsp_t    cur;
    strobe_t s;
    logic    prev_valid;
    logic    prev_we;
    logic    prev_re;
    cur = '{rdata: 8'h00, err: 1'b0, cyc: 0};
    prev_valid = 1'b0;
    prev_we    = 1'b0;
    prev_re    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_valid = 1'b0;
        prev_we    = 1'b0;
        prev_re    = 1'b0;
      end else begin
        if (rsp_valid && !prev_valid) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_rsp", "rsp_valid with no outstanding command");
          end else begin
            cur = sb.pop_front();
            chk("rsp_rdata", 32'(rsp_rdata), 32'(cur.rdata));
            chk("rsp_err", 32'(rsp_err), 32'(cur.err));
            chk("rsp_latency_cycle", cyc, cur.cyc);
          end
        end else if (rsp_valid) begin
          chk("rsp_rdata_stable", 32'(rsp_rdata), 32'(cur.rdata));
          chk("rsp_err_stable", 32'(rsp_err), 32'(cur.err));
          chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
        end
        prev_valid = rsp_valid;

        if (box_write_enable || box_read_enable) begin
          chk("enables_exclusive", 32'(box_write_enable & box_read_enable), 32'd0);
          if (box_write_enable) chk("we_single_cycle", 32'(prev_we), 32'd0);
          if (box_read_enable)  chk("re_single_cycle", 32'(prev_re), 32'd0);
          if (st.size() == 0) begin
            fail_now("unexpected_strobe", "box enable with no outstanding command");
          end else begin
            s = st.pop_front();
            chk("strobe_kind", 32'(box_write_enable), 32'(s.wr));
            chk("strobe_addr", 32'(box_address), 32'(s.addr));
            if (s.wr) chk("strobe_wdata", 32'(box_write_data), 32'(s.data));
          end
        end
        prev_we = box_write_enable;
        prev_re = box_read_enable;
      end
    end
  end

  // Issue one command, predict its response from the reference array, optionally wait for completion.
  // lat: box read latency in edges (0 = never answers); hold < 0 leaves the consumer untouched.
  task automatic do_cmd(input logic wr, input logic [1:0] a, input logic [7:0] d,
                        input int lat, input int hold, input bit drain);
    int unsigned acc;
    bit          ok;
    if (hold >= 0) hold_left = hold;
    if (!wr) box_lat = lat;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_now("cmd_accept_timeout", "cmd_ready never rose");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc       = cyc;
    cmd_valid = 1'b0;
    cmd_wdata = 8'($urandom);
    if (wr) begin
      ref_mem[a] = d;
      sb.push_back('{rdata: 8'h00, err: 1'b0, cyc: acc + 1});
      st.push_back('{wr: 1'b1, addr: a, data: d});
    end else begin
      if (lat >= 1 && lat <= int'(TO))
        sb.push_back('{rdata: ref_mem[a], err: 1'b0, cyc: acc + 1 + int'(lat)});
      else
        sb.push_back('{rdata: 8'h00, err: 1'b1, cyc: acc + 1 + TO});
      st.push_back('{wr: 1'b0, addr: a, data: 8'h00});
    end
    if (drain) begin
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        if (sb.size() == 0 && !rsp_valid) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) fail_now("rsp_drain_timeout", "response not completed");
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    box_lat   = 1;
    hold_left = 0;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 2'd0;
    cmd_wdata = 8'h00;
    for (int i = 0; i < 4; i++) ref_mem[i] = 8'h00;

    // Reset state and release timing.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_enables", 32'({box_write_enable, box_read_enable}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("cmd_ready_before_first_edge", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("cmd_ready_after_first_edge", 32'(cmd_ready), 32'd1);

    // Reset dropped while the write strobe is high.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 2'd3;
    cmd_wdata = 8'h3C;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("we_before_reset", 32'(box_write_enable), 32'd1);
    chk("addr_before_reset", 32'(box_address), 32'd3);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_we", 32'(box_write_enable), 32'd0);
    chk("mid_rst_re", 32'(box_read_enable), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_addr", 32'(box_address), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    sb.delete();
    st.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("cmd_ready_before_first_edge2", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("cmd_ready_after_first_edge2", 32'(cmd_ready), 32'd1);

    // Basic writes and 1-cycle reads.
    do_cmd(1'b1, 2'd0, 8'hAA, 0, 0, 1'b1);
    do_cmd(1'b1, 2'd1, 8'h55, 0, 0, 1'b1);
    do_cmd(1'b0, 2'd0, 8'h00, 1, 0, 1'b1);
    do_cmd(1'b0, 2'd1, 8'h00, 1, 0, 1'b1);

    // Box never answers: timeout error, then normal traffic resumes.
    do_cmd(1'b0, 2'd2, 8'h00, 0, 0, 1'b1);
    do_cmd(1'b1, 2'd2, 8'h9E, 0, 0, 1'b1);
    do_cmd(1'b0, 2'd2, 8'h00, 1, 0, 1'b1);

    // Back-pressure: response held 5 cycles while the next command waits.
    do_cmd(1'b0, 2'd0, 8'h00, 1, 5, 1'b0);
    do_cmd(1'b1, 2'd3, 8'h77, 0, -1, 1'b1);

    // read_active on the last wait edge wins; one edge later is a timeout.
    do_cmd(1'b0, 2'd3, 8'h00, int'(TO), 0, 1'b1);
    do_cmd(1'b0, 2'd1, 8'h00, int'(TO) + 1, 0, 1'b1);

    // read_active while idle must not produce a response.
    @(posedge clk);
    #1;
    box_read_active = 1'b1;
    box_read_data   = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      chk("idle_pulse_no_rsp", 32'(rsp_valid), 32'd0);
      chk("idle_pulse_not_busy", 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1;
    box_read_active = 1'b0;
    do_cmd(1'b0, 2'd0, 8'h00, 2, 0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      logic       wr;
      logic [1:0] a;
      logic [7:0] d;
      wr = 1'($urandom_range(0, 1));
      a  = 2'($urandom_range(0, 3));
      d  = 8'($urandom_range(0, 255));
      do_cmd(wr, a, d, int'($urandom_range(0, TO + 1)), int'($urandom_range(0, 3)), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    chk("strobes_empty", st.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
